// File: rtl/forward_hazard_unit.sv
// Operand forwarding (MEM / WB / writeback history) and load-use stall unit.
// Each EX source picks the youngest in-flight producer; a two-state FSM
// inserts exactly one bubble per load-use pair and counts committed stalls.
module forward_hazard_unit #(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned REGW  = 5,
    parameter int unsigned DATAW = 32,
    parameter int unsigned CNTW  = 16,
    localparam int unsigned SELW = $clog2(DEPTH + 3)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    freeze,
    input  logic [NSRC*REGW-1:0]    ex_src,
    input  logic [NSRC*DATAW-1:0]   ex_src_data,
    input  logic [2*REGW-1:0]       id_src,
    input  logic [REGW-1:0]         ex_rd,
    input  logic                    ex_wen,
    input  logic                    ex_is_load,
    input  logic [REGW-1:0]         mem_rd,
    input  logic                    mem_wen,
    input  logic [DATAW-1:0]        mem_data,
    input  logic [REGW-1:0]         wb_rd,
    input  logic                    wb_wen,
    input  logic [DATAW-1:0]        wb_data,
    output logic [NSRC*SELW-1:0]    fwd_sel,
    output logic [NSRC*DATAW-1:0]   fwd_data,
    output logic                    ld_stall,
    output logic [CNTW-1:0]         stall_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               cnt_inc;
    logic               hz;

    logic [DEPTH-1:0]   hist_vld;
    logic [REGW-1:0]    hist_rd   [DEPTH];
    logic [DATAW-1:0]   hist_data [DEPTH];

    // History valid bits: cleared by reset, shifted on every non-frozen edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            hist_vld <= '0;
        end else if (!freeze) begin
            hist_vld[0] <= wb_wen && (wb_rd != '0);
            for (int k = 1; k < DEPTH; k++) begin
                hist_vld[k] <= hist_vld[k-1];
            end
        end
    end

    // History payload: meaningless unless the matching valid bit is set
    always_ff @(posedge CLK) begin
        if (!freeze) begin
            hist_rd[0]   <= wb_rd;
            hist_data[0] <= wb_data;
            for (int k = 1; k < DEPTH; k++) begin
                hist_rd[k]   <= hist_rd[k-1];
                hist_data[k] <= hist_data[k-1];
            end
        end
    end

    // Per-operand priority select: MEM, WB, youngest history entry, regfile
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic [REGW-1:0]  src;
            logic [SELW-1:0]  sel;
            logic [DATAW-1:0] data;
            logic             hit;
            src  = ex_src[i*REGW +: REGW];
            sel  = '0;
            data = ex_src_data[i*DATAW +: DATAW];
            hit  = 1'b0;
            if (src != '0) begin
                if (mem_wen && (mem_rd == src)) begin
                    sel  = SELW'(1);
                    data = mem_data;
                end else if (wb_wen && (wb_rd == src)) begin
                    sel  = SELW'(2);
                    data = wb_data;
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (!hit && !RST && hist_vld[k] && (hist_rd[k] == src)) begin
                            hit  = 1'b1;
                            sel  = SELW'(k + 3);
                            data = hist_data[k];
                        end
                    end
                end
            end
            fwd_sel[i*SELW +: SELW]    = sel;
            fwd_data[i*DATAW +: DATAW] = data;
        end
    end

    assign hz = ex_wen && ex_is_load && (ex_rd != '0) &&
                ((ex_rd == id_src[0 +: REGW]) || (ex_rd == id_src[REGW +: REGW]));

    // Load-use FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load-use FSM next state and stall output; a freeze holds the stall in IDLE
    always_comb begin
        state_nxt = state;
        ld_stall  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                ld_stall = hz;
                if (hz && !freeze) begin
                    state_nxt = BUBBLE;
                    cnt_inc   = 1'b1;
                end
            end
            BUBBLE: begin
                if (!freeze) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (RST) begin
            ld_stall = 1'b0;
            cnt_inc  = 1'b0;
        end
    end

    // Saturating count of committed stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (cnt_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed scenarios plus randomized traffic
// compared against a queue-based model of forwarding and load-use stalls.
module tb_forward_hazard_unit;

    localparam int unsigned NSRC  = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned REGW  = 5;
    localparam int unsigned DATAW = 32;
    localparam int unsigned CNTW  = 2;
    localparam int unsigned SELW  = $clog2(DEPTH + 3);

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    freeze;
    logic [NSRC*REGW-1:0]    ex_src;
    logic [NSRC*DATAW-1:0]   ex_src_data;
    logic [2*REGW-1:0]       id_src;
    logic [REGW-1:0]         ex_rd;
    logic                    ex_wen;
    logic                    ex_is_load;
    logic [REGW-1:0]         mem_rd;
    logic                    mem_wen;
    logic [DATAW-1:0]        mem_data;
    logic [REGW-1:0]         wb_rd;
    logic                    wb_wen;
    logic [DATAW-1:0]        wb_data;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [NSRC*DATAW-1:0]   fwd_data;
    logic                    ld_stall;
    logic [CNTW-1:0]         stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    forward_hazard_unit #(
        .NSRC(NSRC), .DEPTH(DEPTH), .REGW(REGW), .DATAW(DATAW), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RST(RST), .freeze(freeze),
        .ex_src(ex_src), .ex_src_data(ex_src_data), .id_src(id_src),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .ld_stall(ld_stall), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: list of the last DEPTH retired writebacks, youngest first
    typedef struct {
        logic            v;
        logic [REGW-1:0] rd;
        logic [DATAW-1:0] d;
    } hent_t;

    hent_t hq[$];
    bit    m_bub;
    int    m_cnt;

    logic [SELW-1:0]  exp_sel  [NSRC];
    logic [DATAW-1:0] exp_data [NSRC];
    logic             exp_stall;

    function automatic bit model_hz();
        return ex_wen && ex_is_load && (ex_rd != 0) &&
               (ex_rd == id_src[0 +: REGW] || ex_rd == id_src[REGW +: REGW]);
    endfunction

    function automatic void model_expect();
        logic [REGW-1:0] s;
        bit found;
        exp_stall = !RST && !m_bub && model_hz();
        for (int i = 0; i < NSRC; i++) begin
            s = ex_src[i*REGW +: REGW];
            exp_sel[i]  = '0;
            exp_data[i] = ex_src_data[i*DATAW +: DATAW];
            if (s != 0) begin
                if (mem_wen && mem_rd == s) begin
                    exp_sel[i] = SELW'(1); exp_data[i] = mem_data;
                end else if (wb_wen && wb_rd == s) begin
                    exp_sel[i] = SELW'(2); exp_data[i] = wb_data;
                end else if (!RST) begin
                    found = 0;
                    for (int k = 0; k < hq.size(); k++) begin
                        if (!found && hq[k].v && hq[k].rd == s) begin
                            found = 1;
                            exp_sel[i]  = SELW'(k + 3);
                            exp_data[i] = hq[k].d;
                        end
                    end
                end
            end
        end
    endfunction

    function automatic void model_commit();
        hent_t e;
        bit hz;
        hz = model_hz();
        if (RST) begin
            hq.delete();
            m_bub = 0;
            m_cnt = 0;
        end else if (!freeze) begin
            e.v = wb_wen && (wb_rd != 0); e.rd = wb_rd; e.d = wb_data;
            hq.push_front(e);
            if (hq.size() > DEPTH) void'(hq.pop_back());
            if (m_bub) begin
                m_bub = 0;
            end else if (hz) begin
                m_bub = 1;
                if (m_cnt < (1 << CNTW) - 1) m_cnt++;
            end
        end
    endfunction

    // Advance one clock: model sees the same pre-edge inputs as the DUT
    task automatic cycle();
        model_commit();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        freeze = 0; ex_src = '0; ex_src_data = '0; id_src = '0;
        ex_rd = '0; ex_wen = 0; ex_is_load = 0;
        mem_rd = '0; mem_wen = 0; mem_data = '0;
        wb_rd = '0; wb_wen = 0; wb_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1;
        #3;
        cycle();
        RST = 0;
    endtask

    task automatic set_hz(input logic [REGW-1:0] rd);
        ex_wen = 1; ex_is_load = 1; ex_rd = rd;
        id_src[0 +: REGW] = rd; id_src[REGW +: REGW] = 5'd3;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        set_hz(5'd9);
        ex_src[0 +: REGW] = 5'd5; mem_rd = 5'd5; mem_wen = 1; mem_data = 32'hCAFE;
        #3;
        checks++;
        if (ld_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", ld_stall);
        end
        checks++;
        if (fwd_sel[0 +: SELW] !== SELW'(1) || fwd_data[0 +: DATAW] !== 32'hCAFE) begin
            errors++; $display("FAIL reset_fwd: got sel=%0d data=%h want sel=1 data=cafe",
                               fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
        end
        cycle();
        RST = 0;
        clear_inputs();
        #3;
        checks++;
        if (stall_cnt !== '0 || ld_stall !== 1'b0) begin
            errors++; $display("FAIL reset_state: got cnt=%0d stall=%b want 0 0", stall_cnt, ld_stall);
        end
        cycle();
    endtask

    task automatic test_priority();
        do_reset();
        ex_src[0 +: REGW] = 5'd5; ex_src[REGW +: REGW] = 5'd6;
        ex_src_data = {32'h6666, 32'h5555};
        mem_rd = 5'd5; mem_wen = 1; mem_data = 32'hAAAA;
        wb_rd = 5'd5; wb_wen = 1; wb_data = 32'hBBBB;
        #3;
        checks++;
        if (fwd_sel[0 +: SELW] !== SELW'(1) || fwd_data[0 +: DATAW] !== 32'hAAAA) begin
            errors++; $display("FAIL prio_mem: got sel=%0d data=%h want 1 aaaa",
                               fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
        end
        checks++;
        if (fwd_sel[SELW +: SELW] !== SELW'(0) || fwd_data[DATAW +: DATAW] !== 32'h6666) begin
            errors++; $display("FAIL prio_op1_rf: got sel=%0d data=%h want 0 6666",
                               fwd_sel[SELW +: SELW], fwd_data[DATAW +: DATAW]);
        end
        mem_wen = 0;
        #1;
        checks++;
        if (fwd_sel[0 +: SELW] !== SELW'(2) || fwd_data[0 +: DATAW] !== 32'hBBBB) begin
            errors++; $display("FAIL prio_wb: got sel=%0d data=%h want 2 bbbb",
                               fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
        end
        cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        mem_rd = '0; mem_wen = 1; mem_data = 32'hDEAD;
        wb_rd = '0; wb_wen = 1; wb_data = 32'hBEEF;
        ex_src_data[0 +: DATAW] = 32'h1234;
        #3;
        checks++;
        if (fwd_sel[0 +: SELW] !== SELW'(0) || fwd_data[0 +: DATAW] !== 32'h1234) begin
            errors++; $display("FAIL zero_reg: got sel=%0d data=%h want 0 1234",
                               fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
        end
        cycle();
    endtask

    task automatic test_history_aging();
        logic [SELW-1:0] want_sel [3];
        logic [DATAW-1:0] want_data [3];
        want_sel[0] = SELW'(3); want_sel[1] = SELW'(4); want_sel[2] = SELW'(0);
        want_data[0] = 32'h77; want_data[1] = 32'h77; want_data[2] = 32'h0F0F;
        do_reset();
        wb_rd = 5'd7; wb_wen = 1; wb_data = 32'h77;
        #3;
        cycle();
        wb_wen = 0;
        ex_src[0 +: REGW] = 5'd7; ex_src_data[0 +: DATAW] = 32'h0F0F;
        for (int t = 0; t < 3; t++) begin
            #3;
            checks++;
            if (fwd_sel[0 +: SELW] !== want_sel[t] || fwd_data[0 +: DATAW] !== want_data[t]) begin
                errors++; $display("FAIL hist_age[t+%0d]: got sel=%0d data=%h want sel=%0d data=%h",
                                   t + 1, fwd_sel[0 +: SELW], fwd_data[0 +: DATAW], want_sel[t], want_data[t]);
            end
            cycle();
        end
    endtask

    task automatic test_load_use();
        logic want [3];
        want[0] = 1; want[1] = 0; want[2] = 0;
        do_reset();
        set_hz(5'd9);
        for (int t = 0; t < 3; t++) begin
            if (t == 2) clear_inputs();
            #3;
            checks++;
            if (ld_stall !== want[t]) begin
                errors++; $display("FAIL load_use_stall[%0d]: got %b want %b", t, ld_stall, want[t]);
            end
            cycle();
        end
        #3;
        checks++;
        if (stall_cnt !== CNTW'(1)) begin
            errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
        end
        cycle();
    endtask

    task automatic test_freeze();
        do_reset();
        wb_rd = 5'd11; wb_wen = 1; wb_data = 32'h1111;
        #3;
        cycle();
        wb_rd = 5'd12; wb_data = 32'h2222;
        ex_src[0 +: REGW] = 5'd11;
        set_hz(5'd9);
        freeze = 1;
        for (int t = 0; t < 3; t++) begin
            #3;
            checks++;
            if (ld_stall !== 1'b1 || stall_cnt !== CNTW'(0)) begin
                errors++; $display("FAIL freeze_hold[%0d]: got stall=%b cnt=%0d want 1 0", t, ld_stall, stall_cnt);
            end
            checks++;
            if (fwd_sel[0 +: SELW] !== SELW'(3) || fwd_data[0 +: DATAW] !== 32'h1111) begin
                errors++; $display("FAIL freeze_hist[%0d]: got sel=%0d data=%h want 3 1111",
                                   t, fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
            end
            cycle();
        end
        freeze = 0; wb_wen = 0;
        #3;
        checks++;
        if (ld_stall !== 1'b1) begin
            errors++; $display("FAIL freeze_release: got %b want 1", ld_stall);
        end
        cycle();
        #3;
        checks++;
        if (ld_stall !== 1'b0 || stall_cnt !== CNTW'(1) || fwd_sel[0 +: SELW] !== SELW'(4)) begin
            errors++; $display("FAIL freeze_bubble: got stall=%b cnt=%0d sel=%0d want 0 1 4",
                               ld_stall, stall_cnt, fwd_sel[0 +: SELW]);
        end
        cycle();
    endtask

    task automatic test_reset_mid_bubble();
        do_reset();
        set_hz(5'd9);
        wb_rd = 5'd13; wb_wen = 1; wb_data = 32'h1313;
        #3;
        cycle();
        wb_wen = 0;
        ex_src[0 +: REGW] = 5'd13; ex_src_data[0 +: DATAW] = 32'h5A5A;
        RST = 1;
        #3;
        checks++;
        if (ld_stall !== 1'b0 || fwd_sel[0 +: SELW] !== SELW'(0) || fwd_data[0 +: DATAW] !== 32'h5A5A) begin
            errors++; $display("FAIL rst_bubble_during: got stall=%b sel=%0d data=%h want 0 0 5a5a",
                               ld_stall, fwd_sel[0 +: SELW], fwd_data[0 +: DATAW]);
        end
        cycle();
        RST = 0;
        #3;
        checks++;
        if (ld_stall !== 1'b1 || stall_cnt !== CNTW'(0) || fwd_sel[0 +: SELW] !== SELW'(0)) begin
            errors++; $display("FAIL rst_bubble_after: got stall=%b cnt=%0d sel=%0d want 1 0 0",
                               ld_stall, stall_cnt, fwd_sel[0 +: SELW]);
        end
        clear_inputs();
        cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_hz(5'd9);
            #3;
            cycle();
            #3;
            cycle();
        end
        clear_inputs();
        #3;
        checks++;
        if (stall_cnt !== CNTW'(3)) begin
            errors++; $display("FAIL saturation: got %0d want 3", stall_cnt);
        end
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            RST        = ($urandom_range(0, 99) < 4);
            freeze     = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NSRC; i++) begin
                ex_src[i*REGW +: REGW]       = REGW'($urandom_range(0, 7));
                ex_src_data[i*DATAW +: DATAW] = $urandom;
            end
            id_src[0 +: REGW]    = REGW'($urandom_range(0, 7));
            id_src[REGW +: REGW] = REGW'($urandom_range(0, 7));
            ex_rd      = REGW'($urandom_range(0, 7));
            ex_wen     = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 1) == 1);
            mem_rd     = REGW'($urandom_range(0, 7));
            mem_wen    = ($urandom_range(0, 2) == 0);
            mem_data   = $urandom;
            wb_rd      = REGW'($urandom_range(0, 7));
            wb_wen     = ($urandom_range(0, 1) == 1);
            wb_data    = $urandom;
            #3;
            model_expect();
            for (int i = 0; i < NSRC; i++) begin
                checks++;
                if (fwd_sel[i*SELW +: SELW] !== exp_sel[i] || fwd_data[i*DATAW +: DATAW] !== exp_data[i]) begin
                    errors++; $display("FAIL rand_fwd[%0d] cycle %0d: got sel=%0d data=%h want sel=%0d data=%h",
                                       i, cyc, fwd_sel[i*SELW +: SELW], fwd_data[i*DATAW +: DATAW],
                                       exp_sel[i], exp_data[i]);
                end
            end
            checks++;
            if (ld_stall !== exp_stall || stall_cnt !== CNTW'(m_cnt)) begin
                errors++; $display("FAIL rand_stall cycle %0d: got stall=%b cnt=%0d want stall=%b cnt=%0d",
                                   cyc, ld_stall, stall_cnt, exp_stall, m_cnt);
            end
            cycle();
        end
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        @(posedge CLK);
        #1;
        test_reset();
        test_priority();
        test_zero_reg();
        test_history_aging();
        test_load_use();
        test_freeze();
        test_reset_mid_bubble();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
